// File: rtl/adder_pkg.sv
// adder_pkg: chunk-boundary helpers and configuration legality for pipelined_adder.
package adder_pkg;

    localparam int MAX_WIDTH = 512;

    function automatic int chunk_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int chunk_lo(input int k, input int cw);
        return k * cw;
    endfunction

    // Clamped to the operand MSB; may fall below chunk_lo for an empty trailing chunk.
    function automatic int chunk_hi(input int k, input int cw, input int width);
        return ((k + 1) * cw < width) ? (k + 1) * cw - 1 : width - 1;
    endfunction

    function automatic bit cfg_legal(input int width, input int stages);
        return (width >= 1) && (width <= MAX_WIDTH) && (stages >= 1) && (stages <= width);
    endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// adder_chunk_stage: one registered carry-chunk slice; forwards the operand words.
// Operand inversion for subtraction exists only when ADDER_SUB_EN is defined.
module adder_chunk_stage #(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int HI    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef ADDER_SUB_EN
    input  logic             sub_i,
`endif
    input  logic             cin_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic             cout_d, cout_q;

    if (LO <= HI) begin : g_chunk
        localparam int CWK = HI - LO + 1;
        logic [CWK-1:0] b_chunk;
        logic [CWK:0]   chunk_sum;

        always_comb begin
`ifdef ADDER_SUB_EN
            b_chunk = b_i[HI:LO] ^ {CWK{sub_i}};
`else
            b_chunk = b_i[HI:LO];
`endif
            chunk_sum = {1'b0, a_i[HI:LO]} + {1'b0, b_chunk} + {{CWK{1'b0}}, cin_i};
        end

        // The A word leaves with this chunk replaced by its partial sum.
        always_comb begin
            a_d    = a_q;
            b_d    = b_q;
            cout_d = cout_q;
            if (en) begin
                a_d        = a_i;
                a_d[HI:LO] = chunk_sum[CWK-1:0];
                b_d        = b_i;
                cout_d     = chunk_sum[CWK];
            end
        end
    end else begin : g_empty
        // Empty trailing chunk: only delays the carry so every stage has equal depth.
        always_comb begin
            a_d    = a_q;
            b_d    = b_q;
            cout_d = cout_q;
            if (en) begin
                a_d    = a_i;
                b_d    = b_i;
                cout_d = cin_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            cout_q <= cout_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: operand register, STAGES carry-chunk slices and a result register
// under a global valid/ready stall. Define ADDER_SUB_EN to build the subtract path.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 89,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be 1..512 and STAGES 1..WIDTH");
    end

    logic              advance;
    logic [WIDTH-1:0]  a_d, a_q;
    logic [WIDTH-1:0]  b_d, b_q;
    logic [STAGES+1:0] vld_d, vld_q;
    logic [WIDTH:0]    sum_d, sum_q;
    logic [WIDTH-1:0]  aw [STAGES+1];
    logic [WIDTH-1:0]  bw [STAGES+1];
    logic [STAGES:0]   cy;
`ifdef ADDER_SUB_EN
    logic [STAGES:0]   sub_d, sub_q;
`endif

    // vld_q[0] is the operand register, [1..STAGES] the chunk slices, [STAGES+1] the result.
    always_comb begin
        advance = !vld_q[STAGES+1] || out_ready;
        a_d     = a_q;
        b_d     = b_q;
        vld_d   = vld_q;
        sum_d   = sum_q;
`ifdef ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        if (advance) begin
            a_d   = a;
            b_d   = b;
            vld_d = {vld_q[STAGES:0], in_valid};
`ifdef ADDER_SUB_EN
            sub_d = {sub_q[STAGES-1:0], sub};
            sum_d = {cy[STAGES] ^ sub_q[STAGES], aw[STAGES]};
`else
            sum_d = {cy[STAGES], aw[STAGES]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= '0;
            sum_q <= '0;
`ifdef ADDER_SUB_EN
            sub_q <= '0;
`endif
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vld_q <= vld_d;
            sum_q <= sum_d;
`ifdef ADDER_SUB_EN
            sub_q <= sub_d;
`endif
        end
    end

    assign aw[0] = a_q;
    assign bw[0] = b_q;
`ifdef ADDER_SUB_EN
    assign cy[0] = sub_q[0];
`else
    assign cy[0] = 1'b0;
`endif

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        adder_chunk_stage #(
            .WIDTH (WIDTH),
            .LO    (chunk_lo(k - 1, CW)),
            .HI    (chunk_hi(k - 1, CW, WIDTH))
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (advance),
            .a_i    (aw[k-1]),
            .b_i    (bw[k-1]),
`ifdef ADDER_SUB_EN
            .sub_i  (sub_q[k-1]),
`endif
            .cin_i  (cy[k-1]),
            .a_o    (aw[k]),
            .b_o    (bw[k]),
            .cout_o (cy[k])
        );
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES+1];
    assign sum       = sum_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized checks of pipelined_adder against arithmetic reference
// results; a second group of instances sweeps WIDTH/STAGES.
`timescale 1ns/1ps
module tb_pipelined_adder;

    localparam int W = 89;
    localparam int S = 4;
`ifdef ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam int NSW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic [W-1:0] a, b;
    logic [W:0]   sum;
    int           checks = 0;
    int           failures = 0;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
    );

    function automatic int sw_width(input int i);
        case (i)
            0: return 1;
            1: return 8;
            2: return 89;
            default: return 512;
        endcase
    endfunction

    function automatic int sw_stages(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 89;
            default: return 7;
        endcase
    endfunction

    logic           sw_valid;
    logic [511:0]   sw_a, sw_b;
    logic [NSW-1:0] sw_out_valid, sw_in_ready;
    logic [512:0]   sw_sum [NSW];

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        localparam int SWW = sw_width(i);
        localparam int SWS = sw_stages(i);
        logic [SWW:0] s;
        pipelined_adder #(.WIDTH(SWW), .STAGES(SWS)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[i]),
            .a(sw_a[SWW-1:0]), .b(sw_b[SWW-1:0]), .sub(1'b0),
            .out_valid(sw_out_valid[i]), .out_ready(1'b1), .sum(s)
        );
        assign sw_sum[i] = 513'(s);
    end

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        if (SUB_EN && s) return {1'b0, x} - {1'b0, y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            default: return r[W-1:0];
        endcase
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], $urandom};
        return r;
    endfunction

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; in_valid = 1'b1; a = rand_w(); b = rand_w(); sub = 1'b0;
        out_ready = 1'b1; sw_valid = 1'b0; sw_a = '0; sw_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1; in_valid = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL reset_discard: got %0d results want 0", seen); end
    endtask

    task automatic test_carry_ripple();
        logic [W:0] exp;
        int lat;
        exp = '0; exp[W] = 1'b1;
        a = '1; b = 1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ripple_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (lat < 20 && out_valid !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != S + 1) begin failures++; $display("FAIL ripple_latency: got %0d edges want %0d", lat, S + 1); end
        checks++; if (sum !== exp) begin failures++; $display("FAIL ripple_sum: got %h want %h", sum, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_q[$];
        int         pc_q[$];
        logic [W:0] e;
        int         pc, got, ready_bad;
        got = 0; ready_bad = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            in_valid = (cyc < 100); a = rand_w(); b = rand_w(); sub = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            #1;
            if (in_ready !== 1'b1) ready_bad++;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_extra: unexpected result %h at cycle %0d", sum, cyc);
                end else begin
                    e = exp_q.pop_front(); pc = pc_q.pop_front(); got++;
                    checks++; if (sum !== e) begin failures++; $display("FAIL b2b_sum: got %h want %h", sum, e); end
                    // pushed in cycle pc, visible S+1 edges after the accepting edge
                    checks++; if (cyc - pc != S + 2) begin failures++; $display("FAIL b2b_latency: got %0d want %0d", cyc - pc, S + 2); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(a, b, sub)); pc_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        checks++; if (got != 100) begin failures++; $display("FAIL b2b_count: got %0d want 100", got); end
        checks++; if (ready_bad != 0) begin failures++; $display("FAIL b2b_in_ready: got %0d low cycles want 0", ready_bad); end
    endtask

    task automatic test_backpressure();
        logic [W:0] exp_q[$];
        logic [W:0] e, snap;
        int pushed, popped;
        pushed = 0; popped = 0; snap = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            in_valid = (cyc < 15) ? 1'b1 : (cyc < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
            out_ready = !(cyc >= 15 && cyc < 25);
            a = rand_w(); b = rand_w(); sub = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 15) snap = sum;
            if (cyc >= 15 && cyc < 25) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0 cycle %0d", in_ready, cyc); end
                if (cyc > 15) begin
                    checks++;
                    if (out_valid !== 1'b1 || sum !== snap) begin
                        failures++; $display("FAIL bp_hold: got valid=%b sum=%h want valid=1 sum=%h", out_valid, sum, snap);
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                popped++;
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL bp_extra: unexpected result %h", sum);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (sum !== e) begin failures++; $display("FAIL bp_sum: got %h want %h", sum, e); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(a, b, sub)); pushed++;
            end
            @(posedge clk); #1;
        end
        checks++; if (popped != pushed) begin failures++; $display("FAIL bp_count: got %0d results want %0d", popped, pushed); end
    endtask

    task automatic test_sub_mode();
        logic [W:0] exp [2];
        int n;
        exp[0] = SUB_EN ? ({(W + 1){1'b1}} - 1) : (W + 1)'(12);
        exp[1] = SUB_EN ? (W + 1)'(2) : (W + 1)'(12);
        a = 5; b = 7; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a = 7; b = 5;
        @(posedge clk); #1;
        in_valid = 1'b0; sub = 1'b0;
        n = 0;
        for (int t = 0; t < 20 && n < 2; t++) begin
            if (out_valid === 1'b1) begin
                checks++; if (sum !== exp[n]) begin failures++; $display("FAIL sub_sum%0d: got %h want %h", n, sum, exp[n]); end
                n++;
            end
            @(posedge clk); #1;
        end
        checks++; if (n != 2) begin failures++; $display("FAIL sub_count: got %0d want 2", n); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = rand_w(); b = rand_w(); sub = 1'b0;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin failures++; $display("FAIL midrst_sum: got %h want 0", sum); end
        rst_n = 1'b1; in_valid = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_flush: got %0d results want 0", seen); end
    endtask

    task automatic test_sweep();
        bit           hv [160];
        logic [511:0] ha [160];
        logic [511:0] hb [160];
        logic [511:0] m;
        logic [512:0] e;
        logic         ev;
        int           src;
        for (int cyc = 0; cyc < 160; cyc++) begin
            sw_valid = (cyc < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
            sw_a = rand512(); sw_b = rand512();
            if (cyc % 9 == 0) begin sw_a = '1; sw_b = 512'(1); end
            hv[cyc] = sw_valid; ha[cyc] = sw_a; hb[cyc] = sw_b;
            #1;
            for (int i = 0; i < NSW; i++) begin
                src = cyc - (sw_stages(i) + 2);
                ev = (src >= 0) ? hv[src] : 1'b0;
                checks++;
                if (sw_out_valid[i] !== ev) begin
                    failures++; $display("FAIL sweep%0d_valid: got %b want %b cycle %0d", i, sw_out_valid[i], ev, cyc);
                end
                if (ev) begin
                    m = '1; m = m >> (512 - sw_width(i));
                    e = {1'b0, ha[src] & m} + {1'b0, hb[src] & m};
                    checks++;
                    if (sw_sum[i] !== e) begin
                        failures++; $display("FAIL sweep%0d_sum: got %h want %h", i, sw_sum[i], e);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_back_to_back();
        test_backpressure();
        test_sub_mode();
        test_reset_midflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
